// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// pc_gen : program-counter unit with fetch handshake, redirect, trap and halt
// Revision: 1.0
// ============================================================================
module pc_gen #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = 32'h0000_0100,
    parameter int               INC          = 4,
    parameter int               ALIGN_BITS   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_ready,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_valid,
    output logic            misalign_err,
    output logic            halted
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] STEP = XLEN'(INC);

    state_t state;
    state_t state_d;
    logic   err_d;
    logic   target_misaligned;

    generate
        if (ALIGN_BITS > 0) begin : g_align_chk
            assign target_misaligned = |redirect_target[ALIGN_BITS-1:0];
        end else begin : g_no_align_chk
            assign target_misaligned = 1'b0;
        end
    endgenerate

    // Next-state / next-PC decode; pc_next is exported so it must track every branch below.
    always_comb begin
        state_d = state;
        pc_next = pc_out;
        err_d   = misalign_err;
        case (state)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (trap) begin
                    pc_next = TRAP_VECTOR;
                end else if (redirect_valid) begin
                    if (!target_misaligned) begin
                        pc_next = redirect_target;
                    end else begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end
                end else if (halt_req) begin
                    state_d = HALT;
                end else if (fetch_ready && !stall) begin
                    pc_next = pc_out + STEP;
                end
            end
            HALT: begin
                if (trap) begin
                    pc_next = TRAP_VECTOR;
                    err_d   = 1'b0;
                    state_d = RUN;
                end else if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with pc_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc_out       <= RESET_VECTOR;
            misalign_err <= 1'b0;
            pc_valid     <= 1'b0;
            halted       <= 1'b0;
        end else begin
            state        <= state_d;
            pc_out       <= pc_next;
            misalign_err <= err_d;
            pc_valid     <= (state_d == RUN);
            halted       <= (state_d == HALT);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// tb_pc_gen : directed scoreboard bench for pc_gen (default and wrap-around vectors)
// Revision: 1.0
// ============================================================================
module tb_pc_gen;

    typedef struct {
        logic [31:0] pc;
        logic        v;
        logic        e;
        logic        h;
    } exp_t;

    logic        clk;
    logic        rst_n, rst_b;
    logic        fetch_ready, stall, redirect_valid, trap, halt_req, resume;
    logic [31:0] redirect_target;
    logic        fetch_ready_b;
    logic [31:0] pc_out, pc_next, pc_out_b, pc_next_b;
    logic        pc_valid, misalign_err, halted;
    logic        pc_valid_b, misalign_err_b, halted_b;

    int   total  = 0;
    int   passed = 0;
    exp_t sb[$];
    exp_t cur;

    pc_gen #(
        .XLEN(32), .RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(32'h0000_0100),
        .INC(4), .ALIGN_BITS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap(trap), .halt_req(halt_req), .resume(resume),
        .pc_out(pc_out), .pc_next(pc_next), .pc_valid(pc_valid),
        .misalign_err(misalign_err), .halted(halted)
    );

    pc_gen #(
        .XLEN(32), .RESET_VECTOR(32'hFFFF_FFF8), .TRAP_VECTOR(32'h0000_0100),
        .INC(4), .ALIGN_BITS(2)
    ) dut_wrap (
        .clk(clk), .rst_n(rst_b), .fetch_ready(fetch_ready_b), .stall(1'b0),
        .redirect_valid(1'b0), .redirect_target(32'h0), .trap(1'b0),
        .halt_req(1'b0), .resume(1'b0),
        .pc_out(pc_out_b), .pc_next(pc_next_b), .pc_valid(pc_valid_b),
        .misalign_err(misalign_err_b), .halted(halted_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] pc, input logic v,
                             input logic e, input logic h);
        cur = sb.pop_front();
        chk({tag, ".pc_out"},       pc,        cur.pc);
        chk({tag, ".pc_valid"},     32'(v),    32'(cur.v));
        chk({tag, ".misalign_err"}, 32'(e),    32'(cur.e));
        chk({tag, ".halted"},       32'(h),    32'(cur.h));
    endtask

    // Drive one cycle of inputs, check pc_next before the edge, check registered outputs after.
    task automatic step(input string tag, input logic fr, input logic st, input logic rv,
                        input logic [31:0] rt, input logic tr, input logic hr, input logic rs,
                        input logic [31:0] epc, input logic ev, input logic ee, input logic eh);
        fetch_ready = fr; stall = st; redirect_valid = rv; redirect_target = rt;
        trap = tr; halt_req = hr; resume = rs;
        sb.push_back('{pc: epc, v: ev, e: ee, h: eh});
        #1;
        chk({tag, ".pc_next"}, pc_next, epc);
        @(posedge clk);
        #1;
        pop_check(tag, pc_out, pc_valid, misalign_err, halted);
    endtask

    initial begin
        rst_n = 1'b0; rst_b = 1'b0; fetch_ready_b = 1'b1;
        fetch_ready = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        trap = 1'b0; halt_req = 1'b0; resume = 1'b0;
        #12;
        sb.push_back('{pc: 32'h0, v: 1'b0, e: 1'b0, h: 1'b0});
        pop_check("reset", pc_out, pc_valid, misalign_err, halted);

        // Boot then sequential fetch
        @(negedge clk);
        rst_n = 1'b1;
        step("boot",  1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0, 0);
        step("seq4",  1, 0, 0, 32'h0, 0, 0, 0, 32'h4, 1, 0, 0);
        step("seq8",  1, 0, 0, 32'h0, 0, 0, 0, 32'h8, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            step("stall", 1, 1, 0, 32'h0, 0, 0, 0, 32'h8, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            step("notrdy", 0, 0, 0, 32'h0, 0, 0, 0, 32'h8, 1, 0, 0);
        step("seqC",  1, 0, 0, 32'h0, 0, 0, 0, 32'hC, 1, 0, 0);

        // Redirect beats stall; trap beats redirect; redirect beats fetch
        step("redir_stall", 0, 1, 1, 32'h40, 0, 0, 0, 32'h40,  1, 0, 0);
        step("trap_wins",   1, 0, 1, 32'h80, 1, 0, 0, 32'h100, 1, 0, 0);
        step("redir_fetch", 1, 0, 1, 32'h10, 0, 0, 0, 32'h10,  1, 0, 0);

        // Misaligned redirect halts with sticky error
        step("misalign1",   1, 0, 1, 32'h42, 0, 0, 0, 32'h10, 0, 1, 1);
        step("halt_ignore", 1, 0, 1, 32'h40, 0, 1, 0, 32'h10, 0, 1, 1);
        step("resume",      0, 0, 0, 32'h0,  0, 0, 1, 32'h10, 1, 1, 0);
        step("post_resume", 1, 0, 0, 32'h0,  0, 0, 0, 32'h14, 1, 1, 0);
        step("misalign0",   1, 0, 1, 32'h41, 0, 0, 0, 32'h14, 0, 1, 1);
        step("halt_trap",   0, 0, 0, 32'h0,  1, 0, 1, 32'h100, 1, 0, 0);

        // Explicit halt request outranks fetch
        step("halt_req",    1, 0, 0, 32'h0,  0, 1, 0, 32'h100, 0, 0, 1);
        step("resume2",     1, 0, 0, 32'h0,  0, 0, 1, 32'h100, 1, 0, 0);
        step("redir20",     0, 0, 1, 32'h20, 0, 0, 0, 32'h20,  1, 0, 0);
        step("seq24",       1, 0, 0, 32'h0,  0, 0, 0, 32'h24,  1, 0, 0);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        sb.push_back('{pc: 32'h0, v: 1'b0, e: 1'b0, h: 1'b0});
        pop_check("async_rst", pc_out, pc_valid, misalign_err, halted);
        @(negedge clk);
        rst_n = 1'b1;
        step("reboot", 1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0, 0);
        step("reseq4", 1, 0, 0, 32'h0, 0, 0, 0, 32'h4, 1, 0, 0);

        // Wrap-around instance
        sb.push_back('{pc: 32'hFFFF_FFF8, v: 1'b0, e: 1'b0, h: 1'b0});
        pop_check("wrap_reset", pc_out_b, pc_valid_b, misalign_err_b, halted_b);
        @(negedge clk);
        rst_b = 1'b1;
        sb.push_back('{pc: 32'hFFFF_FFF8, v: 1'b1, e: 1'b0, h: 1'b0});
        sb.push_back('{pc: 32'hFFFF_FFFC, v: 1'b1, e: 1'b0, h: 1'b0});
        sb.push_back('{pc: 32'h0000_0000, v: 1'b1, e: 1'b0, h: 1'b0});
        sb.push_back('{pc: 32'h0000_0004, v: 1'b1, e: 1'b0, h: 1'b0});
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            pop_check("wrap", pc_out_b, pc_valid_b, misalign_err_b, halted_b);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
